// File: rtl/mult_div_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the MIPS mult/div sequencer:
//   - MD_WIDTH / MD_CNT_W : default operand width and iteration counter width
//   - md_state_e          : sequencer FSM states
//   - cond_neg / cond_neg2: conditional two's-complement negate, used both to
//                           take operand magnitudes and to sign-correct results
// The helpers are sized by MD_WIDTH, so the sequencer's WIDTH must equal it.
// -----------------------------------------------------------------------------
package mult_div_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MULT   = 3'd1,
    DIV    = 3'd2,
    FINISH = 3'd3,
    DZERO  = 3'd4
  } md_state_e;

  // Single-width negate: magnitude of a signed operand, or quotient/remainder fix-up.
  function automatic logic [MD_WIDTH-1:0] cond_neg(input logic [MD_WIDTH-1:0] v,
                                                   input logic               neg);
    if (neg) begin
      cond_neg = ~v + {{(MD_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cond_neg = v;
    end
  endfunction

  // Double-width negate for the full product.
  function automatic logic [2*MD_WIDTH-1:0] cond_neg2(input logic [2*MD_WIDTH-1:0] v,
                                                      input logic                 neg);
    if (neg) begin
      cond_neg2 = ~v + {{(2*MD_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cond_neg2 = v;
    end
  endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer_if
// Request/result bundle between the main control FSM (master) and the
// mult/div sequencer (slave).
//   start_mult, start_div : one-cycle operation requests
//   op_a, op_b            : rs / rt operands, sampled in the start cycle
//   busy, done, div_zero  : status (done and div_zero are one-cycle pulses)
//   hi, lo                : HI / LO architectural registers
// -----------------------------------------------------------------------------
interface mult_div_sequencer_if import mult_div_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
);
  logic             start_mult;
  logic             start_div;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_mult, start_div, op_a, op_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start_mult, start_div, op_a, op_b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_step.sv
// -----------------------------------------------------------------------------
// mult_div_step
// Purely combinational single radix-2 iteration on unsigned magnitudes.
//   is_div = 0 (shift-add multiply):
//     acc_i : running product, opa_i : multiplicand shifted left by the
//     iteration index, opb_i : multiplier bits not yet consumed.
//   is_div = 1 (restoring divide):
//     acc_i = {remainder, dividend/quotient shift register}, opa_i[W-1:0] :
//     divisor, opb_i : unused and passed through.
//   acc_o, opa_o, opb_o : state for the next iteration.
// -----------------------------------------------------------------------------
module mult_div_step import mult_div_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0]   opb_o
);

  logic [WIDTH:0] partial_s;
  logic [WIDTH:0] diff_s;

  // One multiply or divide iteration.
  always_comb begin
    // Remainder stays below the divisor, so partial < 2*divisor and diff[WIDTH]
    // is exactly the borrow of the trial subtraction.
    partial_s = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff_s    = partial_s - {1'b0, opa_i[WIDTH-1:0]};
    acc_o     = acc_i;
    opa_o     = opa_i;
    opb_o     = opb_i;
    if (is_div) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {partial_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (opb_i[0]) begin
        acc_o = acc_i + opa_i;
      end else begin
        acc_o = acc_i;
      end
      opa_o = {opa_i[2*WIDTH-2:0], 1'b0};
      opb_o = {1'b0, opb_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer
// Multicycle sequencer and iterative datapath for MIPS signed mult/div. Owns
// HI/LO and runs one radix-2 iteration per clock via mult_div_step.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any operation and clears HI/LO
//   bus   : mult_div_sequencer_if.slave (requests, operands, status, HI/LO)
// Build option:
//   MULT_DIV_EARLY_EXIT_EN : multiply finishes as soon as the remaining
//                            multiplier bits are all zero. Results unchanged.
// -----------------------------------------------------------------------------
module mult_div_sequencer import mult_div_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input logic                  clock,
  input logic                  reset,
  mult_div_sequencer_if.slave  bus
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;   // product / quotient sign
  logic               neg_hi_q, neg_hi_d;   // remainder sign
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic [2*WIDTH-1:0] step_acc_s;
  logic [2*WIDTH-1:0] step_opa_s;
  logic [WIDTH-1:0]   step_opb_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               last_iter_s;
  logic               mult_last_s;

  mult_div_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .opa_i  (opa_q),
    .opb_i  (opb_q),
    .acc_o  (step_acc_s),
    .opa_o  (step_opa_s),
    .opb_o  (step_opb_s)
  );

  // Next-state, datapath update and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    abs_a_s  = cond_neg(bus.op_a, bus.op_a[WIDTH-1]);
    abs_b_s  = cond_neg(bus.op_b, bus.op_b[WIDTH-1]);
    prod_s   = cond_neg2(acc_q, neg_lo_q);
    last_iter_s = (cnt_q == CNT_W'(WIDTH-1));
`ifdef MULT_DIV_EARLY_EXIT_EN
    mult_last_s = last_iter_s || (step_opb_s == {WIDTH{1'b0}});
`else
    mult_last_s = last_iter_s;
`endif

    case (state_q)
      IDLE: begin
        // Multiply has priority over a simultaneous divide request.
        if (bus.start_mult) begin
          state_d  = MULT;
          cnt_d    = {CNT_W{1'b0}};
          acc_d    = {(2*WIDTH){1'b0}};
          opa_d    = {{WIDTH{1'b0}}, abs_a_s};
          opb_d    = abs_b_s;
          is_div_d = 1'b0;
          neg_lo_d = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          neg_hi_d = bus.op_a[WIDTH-1];
        end else if (bus.start_div) begin
          if (bus.op_b != {WIDTH{1'b0}}) begin
            state_d  = DIV;
            cnt_d    = {CNT_W{1'b0}};
            acc_d    = {{WIDTH{1'b0}}, abs_a_s};
            opa_d    = {{WIDTH{1'b0}}, abs_b_s};
            opb_d    = {WIDTH{1'b0}};
            is_div_d = 1'b1;
            neg_lo_d = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            neg_hi_d = bus.op_a[WIDTH-1];
          end else begin
            state_d = DZERO;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MULT, DIV: begin
        acc_d = step_acc_s;
        opa_d = step_opa_s;
        opb_d = step_opb_s;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if ((state_q == MULT) ? mult_last_s : last_iter_s) begin
          state_d = FINISH;
        end else begin
          state_d = state_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (is_div_q) begin
          lo_d = cond_neg(acc_q[WIDTH-1:0], neg_lo_q);
          hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_hi_q);
        end else begin
          lo_d = prod_s[WIDTH-1:0];
          hi_d = prod_s[2*WIDTH-1:WIDTH];
        end
      end
      DZERO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH) || (state_d == DZERO);
    dz_d   = (state_d == DZERO);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opa_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mult_div_sequencer
// Directed, table-driven bench for mult_div_sequencer plus hand-written
// sequences for a start while busy and a reset in the middle of a divide.
// Cycle 0 is the cycle in which a start request is driven.
// -----------------------------------------------------------------------------
module tb_mult_div_sequencer;

`ifdef MULT_DIV_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc_fixed;
    int          cyc_early;
    logic        dz;
    logic        keep;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] model_hi = 32'h0;
  logic [31:0] model_lo = 32'h0;
  vec_t vecs [13];

  mult_div_sequencer_if #(.WIDTH(32)) bus ();

  mult_div_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Runs one operation from cycle 0; inj > 0 drives a stray start_div in that cycle.
  task automatic run_op(input vec_t v, input int inj, input string tag);
    int          done_cyc = 0;
    int          done_cnt = 0;
    int          busy_err = 0;
    logic        dz_seen = 1'b0;
    logic [31:0] hi_at_done = 32'h0;
    logic [31:0] lo_at_done = 32'h0;
    logic [31:0] hi_new = 32'h0;
    logic [31:0] lo_new = 32'h0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
    bus.start_mult = v.sm;
    bus.start_div  = v.sd;
    bus.op_a       = v.a;
    bus.op_b       = v.b;
    @(posedge clock); #1;
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = 32'hDEADBEEF;
    bus.op_b       = 32'h0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done_cyc != 0 && cyc == done_cyc + 1) begin
        hi_new = bus.hi;
        lo_new = bus.lo;
        if (bus.busy) busy_err++;
        break;
      end
      if (!bus.busy) busy_err++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc   = cyc;
          dz_seen    = bus.div_zero;
          hi_at_done = bus.hi;
          lo_at_done = bus.lo;
        end
      end
      if (cyc == inj) begin
        bus.start_div = 1'b1;
        bus.op_a      = 32'h00001234;
        bus.op_b      = 32'h0;
      end
      @(posedge clock); #1;
      bus.start_div = 1'b0;
    end
    // Nothing further may happen once the operation is over.
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      if (bus.busy || bus.done) busy_err++;
    end
    exp_cyc = EARLY ? v.cyc_early : v.cyc_fixed;
    exp_hi  = v.keep ? model_hi : v.ehi;
    exp_lo  = v.keep ? model_lo : v.elo;
    check({tag, " done_cycle"},  64'(done_cyc), 64'(exp_cyc));
    check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_profile"}, 64'(busy_err), 64'd0);
    check({tag, " div_zero"},    64'(dz_seen), 64'(v.dz));
    check({tag, " hi_held"},     64'(hi_at_done), 64'(model_hi));
    check({tag, " lo_held"},     64'(lo_at_done), 64'(model_lo));
    check({tag, " hi"},          64'(hi_new), 64'(exp_hi));
    check({tag, " lo"},          64'(lo_new), 64'(exp_lo));
    model_hi = exp_hi;
    model_lo = exp_lo;
  endtask

  initial begin
    vec_t col_v;
    vec_t rst_v;
    int   late_done;
    //          sm    sd    a             b             fix early dz    keep  hi            lo
    vecs[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 33, 3,  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 33, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 33, 1'b0, 1'b0, 32'h00000000, 32'h80000000};
    vecs[3]  = '{1'b0, 1'b1, 32'h00000064, 32'hFFFFFFF9, 33, 33, 1'b0, 1'b0, 32'h00000002, 32'hFFFFFFF2};
    vecs[4]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 32, 1'b0, 1'b0, 32'h3FFFFFFF, 32'h00000001};
    vecs[5]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 33, 33, 1'b0, 1'b0, 32'h40000000, 32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFB, 33, 4,  1'b0, 1'b0, 32'h00000000, 32'h00000019};
    vecs[7]  = '{1'b1, 1'b1, 32'h00000006, 32'h00000007, 33, 4,  1'b0, 1'b0, 32'h00000000, 32'h0000002A};
    vecs[8]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000001, 33, 2,  1'b0, 1'b0, 32'h00000000, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b0, 32'h00000009, 32'h00000000, 33, 2,  1'b0, 1'b0, 32'h00000000, 32'h00000000};
    vecs[10] = '{1'b0, 1'b1, 32'h00000451, 32'h00000020, 33, 33, 1'b0, 1'b0, 32'h00000011, 32'h00000022};
    vecs[11] = '{1'b0, 1'b1, 32'h00000005, 32'h00000000, 1,  1,  1'b1, 1'b1, 32'h00000000, 32'h00000000};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h80000000, 33, 33, 1'b0, 1'b0, 32'h00000000, 32'h80000000};

    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.op_a       = 32'h0;
    bus.op_b       = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset busy",     64'(bus.busy), 64'd0);
    check("reset done",     64'(bus.done), 64'd0);
    check("reset div_zero", 64'(bus.div_zero), 64'd0);
    check("reset hi",       64'(bus.hi), 64'd0);
    check("reset lo",       64'(bus.lo), 64'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Stray divide-by-zero request in cycle 10 of a multiply must be dropped.
    col_v = '{1'b1, 1'b0, 32'h00000003, 32'h40000000, 33, 32, 1'b0, 1'b0, 32'h00000000, 32'hC0000000};
    run_op(col_v, 10, "busy_collision");

    // Reset in cycle 15 of a divide: abort, clear HI/LO, no done pulse.
    run_op(vecs[10], 0, "pre_reset_div");
    bus.start_div = 1'b1;
    bus.op_a      = 32'h00000451;
    bus.op_b      = 32'h00000020;
    @(posedge clock); #1;
    bus.start_div = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midreset busy", 64'(bus.busy), 64'd0);
    check("midreset done", 64'(bus.done), 64'd0);
    check("midreset hi",   64'(bus.hi), 64'd0);
    check("midreset lo",   64'(bus.lo), 64'd0);
    late_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (bus.done || bus.busy) late_done++;
    end
    check("midreset no_done", 64'(late_done), 64'd0);
    model_hi = 32'h0;
    model_lo = 32'h0;
    rst_v = '{1'b1, 1'b0, 32'h00000005, 32'h00000006, 33, 4, 1'b0, 1'b0, 32'h00000000, 32'h0000001E};
    run_op(rst_v, 0, "post_reset_mult");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
